hw_qsys_cpu_debug_host_driver: RTL and testbench



---
 rtl/hw_qsys_cpu_debug_host_pkg.sv | 25 ++
 rtl/hw_qsys_cpu_debug_host_if.sv | 28 ++
 rtl/hw_qsys_cpu_debug_host_tckgen.sv | 51 +++++
 rtl/hw_qsys_cpu_debug_host_driver.sv | 213 +++++++++++++++++++++
 tb/tb_hw_qsys_cpu_debug_host_driver.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hw_qsys_cpu_debug_host_pkg.sv
// Shared types and constants for the Nios II debug-slave virtual-JTAG host driver.
package hw_qsys_cpu_debug_host_pkg;

  localparam int unsigned DEF_DR_WIDTH   = 38;
  localparam int unsigned DEF_IR_WIDTH   = 2;
  localparam int unsigned DEF_TCK_DIV    = 2;
  localparam int unsigned DEF_RTI_CYCLES = 2;

  // Virtual IR codes understood by the debug slave
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RSP
  } state_e;

endpackage

// File: rtl/hw_qsys_cpu_debug_host_if.sv
// Command/response handshake between a requester (master) and the host driver (slave).
interface hw_qsys_cpu_debug_host_if
  import hw_qsys_cpu_debug_host_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

endinterface

// File: rtl/hw_qsys_cpu_debug_host_tckgen.sv
// TCK divider: vji_tck toggles every TCK_DIV clk cycles while run is high and idles low.
// rise_pulse/fall_pulse flag the clk cycle whose closing edge makes TCK rise/fall.
module hw_qsys_cpu_debug_host_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tck_q, tck_d;
  logic             term;

  assign term       = run && (div_q == DIV_W'(TCK_DIV - 1));
  assign rise_pulse = term && !tck_q;
  assign fall_pulse = term && tck_q;
  assign tck        = tck_q;

  // Divider advance and TCK toggle at terminal count
  always_comb begin
    div_d = div_q;
    tck_d = tck_q;
    if (!run) begin
      div_d = '0;
      tck_d = 1'b0;
    end else if (term) begin
      div_d = '0;
      tck_d = ~tck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider and TCK registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/hw_qsys_cpu_debug_host_driver.sv
// Virtual-JTAG initiator for the Nios II debug slave: runs UIR/CDR/SDR/UDR/RTI per command
// and returns the captured TDO word.
// Optional: HW_QSYS_DEBUG_HOST_SKIP_IR_EN skips UIR when the IR repeats the last completed one.
module hw_qsys_cpu_debug_host_driver
  import hw_qsys_cpu_debug_host_pkg::*;
#(
  parameter int unsigned DR_WIDTH   = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH   = DEF_IR_WIDTH,
  parameter int unsigned TCK_DIV    = DEF_TCK_DIV,
  parameter int unsigned RTI_CYCLES = DEF_RTI_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hw_qsys_cpu_debug_host_if.slave host,
  output logic                    vji_tck,
  output logic                    vji_tdi,
  input  logic                    vji_tdo,
  output logic [IR_WIDTH-1:0]     vji_ir_in,
  input  logic [IR_WIDTH-1:0]     vji_ir_out,
  output logic                    vji_uir,
  output logic                    vji_cdr,
  output logic                    vji_sdr,
  output logic                    vji_udr,
  output logic                    vji_rti
);

  localparam int unsigned CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tdi_q, tdi_d;
  logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] sr_shift;
  logic                run, rise, fall, skip_ir;

  assign run      = (state_q != ST_IDLE) && (state_q != ST_RSP);
  assign sr_shift = sr_q >> 1;

  hw_qsys_cpu_debug_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .tck        (vji_tck),
    .rise_pulse (rise),
    .fall_pulse (fall)
  );

`ifdef HW_QSYS_DEBUG_HOST_SKIP_IR_EN
  logic [IR_WIDTH-1:0] last_ir_q, last_ir_d;
  logic                last_vld_q, last_vld_d;

  // Remember the IR of the most recently completed command
  always_comb begin
    last_ir_d  = last_ir_q;
    last_vld_d = last_vld_q;
    if ((state_q == ST_RTI) && (state_d == ST_RSP)) begin
      last_ir_d  = ir_q;
      last_vld_d = 1'b1;
    end
  end

  // Last-IR registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_ir_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_ir_q  <= last_ir_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign skip_ir = last_vld_q && (host.cmd_ir == last_ir_q);
`else
  assign skip_ir = 1'b0;
`endif

  // Sequencer: phase transitions on TCK fall, TDO capture on TCK rise
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    sr_d       = sr_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    rsp_ir_d   = rsp_ir_q;
    cnt_d      = cnt_q;
    tdi_d      = tdi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid && cmd_ready_q) begin
          ir_d    = host.cmd_ir;
          sr_d    = host.cmd_dr;
          cap_d   = '0;
          cnt_d   = '0;
          state_d = skip_ir ? ST_CDR : ST_UIR;
        end
      end
      ST_UIR: begin
        if (fall) state_d = ST_CDR;
      end
      ST_CDR: begin
        if (fall) begin
          state_d = ST_SDR;
          cnt_d   = CNT_W'(DR_WIDTH - 1);
          tdi_d   = sr_q[0];
        end
      end
      ST_SDR: begin
        if (rise) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
        if (fall) begin
          if (cnt_q == '0) begin
            state_d = ST_UDR;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            sr_d  = sr_shift;
            tdi_d = sr_shift[0];
          end
        end
      end
      ST_UDR: begin
        if (rise) rsp_ir_d = vji_ir_out;
        if (fall) begin
          state_d = ST_RTI;
          cnt_d   = CNT_W'(RTI_CYCLES - 1);
        end
      end
      ST_RTI: begin
        if (fall) begin
          if (cnt_q == '0) begin
            state_d    = ST_RSP;
            rsp_data_d = cap_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_RSP: begin
        if (host.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    uir_d       = (state_d == ST_UIR);
    cdr_d       = (state_d == ST_CDR);
    sdr_d       = (state_d == ST_SDR);
    udr_d       = (state_d == ST_UDR);
    rti_d       = (state_d == ST_RTI);
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      sr_q        <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      cnt_q       <= '0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      sr_q        <= sr_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      cnt_q       <= cnt_d;
      tdi_q       <= tdi_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign host.cmd_ready  = cmd_ready_q;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_data   = rsp_data_q;
  assign host.rsp_ir_out = rsp_ir_q;
  assign vji_tdi         = tdi_q;
  assign vji_ir_in       = ir_q;
  assign vji_uir         = uir_q;
  assign vji_cdr         = cdr_q;
  assign vji_sdr         = sdr_q;
  assign vji_udr         = udr_q;
  assign vji_rti         = rti_q;

endmodule

// File: tb/tb_hw_qsys_cpu_debug_host_driver.sv
// Directed bench for the debug host driver with a TDI->TDO one-TCK loopback slave model.
module tb_hw_qsys_cpu_debug_host_driver;
  import hw_qsys_cpu_debug_host_pkg::*;

  localparam int LAT_FULL = 172;
`ifdef HW_QSYS_DEBUG_HOST_SKIP_IR_EN
  localparam int LAT_REPEAT = 168;
  localparam int UIR_REPEAT = 0;
`else
  localparam int LAT_REPEAT = 172;
  localparam int UIR_REPEAT = 4;
`endif

  logic       clk;
  logic       reset_n;
  logic       vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic       vji_tdo = 1'b0;
  logic [1:0] vji_ir_in;
  logic [1:0] vji_ir_out;

  int n_checks = 0;
  int n_err    = 0;

  hw_qsys_cpu_debug_host_if #(.DR_WIDTH(38), .IR_WIDTH(2)) host ();

  hw_qsys_cpu_debug_host_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host       (host),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback slave: TDO returns the TDI seen one TCK rise earlier
  always @(posedge vji_tck) vji_tdo = vji_tdi;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command, then follow it until rsp_valid, gathering strobe statistics
  task automatic send_cmd(input logic [1:0] ir, input logic [37:0] dr, output int lat,
                          output int n_uir, output int n_cdr, output int n_sdr,
                          output int n_udr, output int n_rti, output int n_sdr_rise,
                          output int n_rise, output int n_ir_bad);
    logic prev_tck;
    lat = -1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    n_sdr_rise = 0; n_rise = 0; n_ir_bad = 0;
    host.cmd_ir    = ir;
    host.cmd_dr    = dr;
    host.cmd_valid = 1'b1;
    tick();
    host.cmd_valid = 1'b0;
    prev_tck = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      if (k > 0) tick();
      if (host.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (vji_uir) n_uir++;
      if (vji_cdr) n_cdr++;
      if (vji_sdr) n_sdr++;
      if (vji_udr) n_udr++;
      if (vji_rti) n_rti++;
      if (vji_tck && !prev_tck) begin
        n_rise++;
        if (vji_sdr) n_sdr_rise++;
      end
      prev_tck = vji_tck;
      if (vji_ir_in !== ir) n_ir_bad++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (host.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", host.cmd_ready);
    end
    n_checks++;
    if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 7'b0) begin
      n_err++; $display("FAIL reset_vji: got %b expected 0000000",
                        {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
    end
    n_checks++;
    if ({host.rsp_valid, host.rsp_data, host.rsp_ir_out, vji_ir_in} !== 43'b0) begin
      n_err++; $display("FAIL reset_rsp: valid=%b data=%h ir_out=%h ir_in=%h expected all 0",
                        host.rsp_valid, host.rsp_data, host.rsp_ir_out, vji_ir_in);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (host.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", host.cmd_ready);
    end
  endtask

  task automatic test_single();
    int lat, nu, nc, ns, nd, nr, nsr, nrise, nbad;
    vji_ir_out = 2'd1;
    send_cmd(IR_BREAK, 38'h2A_5555_AAAA, lat, nu, nc, ns, nd, nr, nsr, nrise, nbad);
    n_checks++;
    if (lat !== LAT_FULL) begin
      n_err++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT_FULL);
    end
    n_checks++;
    if (host.rsp_data !== 38'h14_AAAB_5554) begin
      n_err++; $display("FAIL single_data: got %h expected 14aaab5554", host.rsp_data);
    end
    n_checks++;
    if (nbad !== 0) begin
      n_err++; $display("FAIL single_ir_in: %0d cycles off, required 0", nbad);
    end
    n_checks++;
    if (host.rsp_ir_out !== 2'd1) begin
      n_err++; $display("FAIL single_ir_out: got %0d expected 1", host.rsp_ir_out);
    end
    tick();
    n_checks++;
    if ({host.rsp_valid, host.cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL single_consume: valid,ready=%b expected 01",
                        {host.rsp_valid, host.cmd_ready});
    end
  endtask

  task automatic test_strobes();
    int lat, nu, nc, ns, nd, nr, nsr, nrise, nbad;
    logic [37:0] dr;
    logic [37:0] exp_data;
    dr = 38'h3F_0F0F_1234;
    exp_data = {dr[36:0], 1'b0};
    vji_ir_out = 2'd3;
    send_cmd(IR_TRACECTRL, dr, lat, nu, nc, ns, nd, nr, nsr, nrise, nbad);
    n_checks++;
    if (nsr !== 38) begin
      n_err++; $display("FAIL strobe_sdr_rises: got %0d expected 38", nsr);
    end
    n_checks++;
    if ({nu, nc, nd} !== {32'd4, 32'd4, 32'd4}) begin
      n_err++; $display("FAIL strobe_uir_cdr_udr: got %0d/%0d/%0d expected 4/4/4", nu, nc, nd);
    end
    n_checks++;
    if (nr !== 8) begin
      n_err++; $display("FAIL strobe_rti: got %0d expected 8", nr);
    end
    n_checks++;
    if (ns !== 152) begin
      n_err++; $display("FAIL strobe_sdr_cycles: got %0d expected 152", ns);
    end
    n_checks++;
    if (nrise !== 43) begin
      n_err++; $display("FAIL strobe_total_rises: got %0d expected 43", nrise);
    end
    n_checks++;
    if (host.rsp_data !== exp_data) begin
      n_err++; $display("FAIL strobe_data: got %h expected %h", host.rsp_data, exp_data);
    end
    n_checks++;
    if (host.rsp_ir_out !== 2'd3) begin
      n_err++; $display("FAIL strobe_ir_out: got %0d expected 3", host.rsp_ir_out);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    int lat, nu, nc, ns, nd, nr, nsr, nrise, nbad, nstall;
    logic [37:0] dr;
    logic [37:0] held;
    dr = 38'h15_A5A5_0FF1;
    vji_ir_out = 2'd2;
    host.rsp_ready = 1'b0;
    send_cmd(IR_TRACEMEM, dr, lat, nu, nc, ns, nd, nr, nsr, nrise, nbad);
    held = host.rsp_data;
    n_checks++;
    if (held !== {dr[36:0], 1'b0}) begin
      n_err++; $display("FAIL bp_data: got %h expected %h", held, {dr[36:0], 1'b0});
    end
    host.cmd_ir    = IR_OCIMEM;
    host.cmd_dr    = 38'h00_1234_5678;
    host.cmd_valid = 1'b1;
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (host.rsp_valid !== 1'b1 || host.rsp_data !== held || vji_tck !== 1'b0 ||
          host.cmd_ready !== 1'b0 ||
          {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 5'b0) nstall++;
    end
    n_checks++;
    if (nstall !== 0) begin
      n_err++; $display("FAIL bp_stall: %0d bad cycles, required 0", nstall);
    end
    host.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({host.cmd_ready, host.rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL bp_release: ready,valid=%b expected 10",
                        {host.cmd_ready, host.rsp_valid});
    end
    tick();
    host.cmd_valid = 1'b0;
    n_checks++;
    if ({vji_uir, host.cmd_ready, vji_ir_in} !== 4'b1000) begin
      n_err++; $display("FAIL bp_next_accept: uir,ready,ir_in=%b expected 1000",
                        {vji_uir, host.cmd_ready, vji_ir_in});
    end
  endtask

  task automatic test_reset_mid_sdr();
    int lat, nu, nc, ns, nd, nr, nsr, nrise, nbad, rises, nvalid;
    logic prev_tck;
    logic [37:0] dr;
    rises = 0;
    prev_tck = vji_tck;
    for (int i = 0; i < 400 && rises < 10; i++) begin
      tick();
      if (vji_tck && !prev_tck && vji_sdr) rises++;
      prev_tck = vji_tck;
    end
    n_checks++;
    if (rises !== 10) begin
      n_err++; $display("FAIL midsdr_reach: got %0d rises expected 10", rises);
    end
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({host.cmd_ready, host.rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
         vji_udr, vji_rti, vji_ir_in} !== 11'b100_0000_0000) begin
      n_err++; $display("FAIL midsdr_reset_vals: got %b expected 10000000000",
                        {host.cmd_ready, host.rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr,
                         vji_sdr, vji_udr, vji_rti, vji_ir_in});
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (host.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL midsdr_ready: got %b expected 1", host.cmd_ready);
    end
    nvalid = 0;
    for (int i = 0; i < 200; i++) begin
      if (host.rsp_valid !== 1'b0 || vji_tck !== 1'b0) nvalid++;
      tick();
    end
    n_checks++;
    if (nvalid !== 0) begin
      n_err++; $display("FAIL midsdr_no_rsp: %0d active cycles, required 0", nvalid);
    end
    dr = 38'h2B_DEAD_BEEF;
    send_cmd(IR_BREAK, dr, lat, nu, nc, ns, nd, nr, nsr, nrise, nbad);
    n_checks++;
    if (lat !== LAT_FULL || host.rsp_data !== {dr[36:0], 1'b0}) begin
      n_err++; $display("FAIL midsdr_followup: lat=%0d data=%h expected %0d %h",
                        lat, host.rsp_data, LAT_FULL, {dr[36:0], 1'b0});
    end
    tick();
  endtask

  task automatic test_skip_ir();
    int lat, nu, nc, ns, nd, nr, nsr, nrise, nbad;
    logic [37:0] dr;
    send_cmd(IR_OCIMEM, 38'h01_0000_0001, lat, nu, nc, ns, nd, nr, nsr, nrise, nbad);
    n_checks++;
    if (lat !== LAT_FULL || nu !== 4) begin
      n_err++; $display("FAIL skip_first: lat=%0d uir=%0d expected %0d 4", lat, nu, LAT_FULL);
    end
    tick();
    dr = 38'h30_C3C3_3C3C;
    send_cmd(IR_OCIMEM, dr, lat, nu, nc, ns, nd, nr, nsr, nrise, nbad);
    n_checks++;
    if (lat !== LAT_REPEAT) begin
      n_err++; $display("FAIL skip_latency: got %0d expected %0d", lat, LAT_REPEAT);
    end
    n_checks++;
    if (nu !== UIR_REPEAT) begin
      n_err++; $display("FAIL skip_uir: got %0d expected %0d", nu, UIR_REPEAT);
    end
    n_checks++;
    if (host.rsp_data !== {dr[36:0], 1'b0}) begin
      n_err++; $display("FAIL skip_data: got %h expected %h", host.rsp_data, {dr[36:0], 1'b0});
    end
    tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    host.cmd_valid = 1'b0;
    host.cmd_ir    = 2'd0;
    host.cmd_dr    = '0;
    host.rsp_ready = 1'b1;
    vji_ir_out     = 2'd0;
    test_reset();
    test_single();
    test_strobes();
    test_back_pressure();
    test_reset_mid_sdr();
    test_skip_ir();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
